// File: rtl/ram_pkg.sv
// Shared types, constants and helpers for the simple-dual-port RAM.
// Used by the clear sequencer and the RAM top level.
package ram_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Widest word the merge helper handles.
    localparam int MAX_DATA_W = 512;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } clr_state_e;

    // Take each byte from new_word where its enable bit is set.
    // Otherwise keep the byte from old_word.
    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Legal parameter combinations, checked at elaboration.
    function automatic bit params_ok(
        input int data_w,
        input int read_latency
    );
        return (data_w > 0) && (data_w % 8 == 0) &&
               (data_w <= MAX_DATA_W) &&
               ((read_latency == 1) || (read_latency == 2));
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: sweeps CLEAR_VALUE over the array after reset
// or on request, and gates user access through ready_o.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    output logic              ready_o,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // State and sweep counter; reset starts a fresh sweep at address 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: sweep to the last word, then wait for clear_i.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign ready_o  = (state_q == ST_IDLE);
    assign clr_we   = (state_q == ST_CLEAR);
    assign clr_addr = cnt_q;

endmodule

// File: rtl/ram_sdp_clr.sv
// Simple-dual-port RAM with byte enables, 1- or 2-cycle reads,
// selectable read-during-write result and a hardware clear sweep.
module ram_sdp_clr
    import ram_pkg::*;
#(
    parameter int                ADDR_W       = 12,
    parameter int                DATA_W       = 16,
    parameter int                READ_LATENCY = 1,
    parameter int                RDW_MODE     = 0,
    parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_i,
    output logic                ready_o,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int BE_W  = DATA_W / 8;

    if (!params_ok(DATA_W, READ_LATENCY)) begin : g_bad_params
        $error("ram_sdp_clr: DATA_W must be a multiple of 8, READ_LATENCY 1 or 2");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              wr_acc;
    logic              rd_acc;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_wbe;

    logic [MAX_DATA_W-1:0] merged_full;
    logic [DATA_W-1:0]     rd_word;

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;

    ram_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (clear_i),
        .ready_o  (ready_o),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign wr_acc = wr_en & ready_o;
    assign rd_acc = rd_en & ready_o;

    // Write port mux: the sweep owns the array whenever ready_o is low.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        mem_wbe   = wr_be;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
            mem_wdata = CLEAR_VALUE;
            mem_wbe   = '1;
        end else if (wr_acc) begin
            mem_we = 1'b1;
        end
    end

    // Byte-lane array write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (mem_we && mem_wbe[i]) begin
                mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    // Read word, optionally forwarding a same-address user write.
    always_comb begin
        merged_full = byte_merge(MAX_DATA_W'(mem[rd_addr]),
                                 MAX_DATA_W'(wr_data),
                                 MAX_BE_W'(wr_be));
        rd_word = mem[rd_addr];
        if ((RDW_MODE == RDW_NEW) && wr_acc && (wr_addr == rd_addr)) begin
            rd_word = merged_full[DATA_W-1:0];
        end
    end

    // First read stage: capture only on accepted reads so data holds.
    always_comb begin
        s1_valid_d = rd_acc;
        s1_data_d  = rd_acc ? rd_word : s1_data_q;
    end

    // First read stage registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic              s2_valid_q, s2_valid_d;
        logic [DATA_W-1:0] s2_data_q, s2_data_d;

        // Output stage: forward stage-1 results, hold otherwise.
        always_comb begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
        end

        // Output stage registers.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s2_valid_d;
                s2_data_q  <= s2_data_d;
            end
        end

        assign rd_data  = s2_data_q;
        assign rd_valid = s2_valid_q;
    end else begin : g_lat1
        assign rd_data  = s1_data_q;
        assign rd_valid = s1_valid_q;
    end

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Bench for ram_sdp_clr: two configurations driven in lockstep and
// compared against an array/queue reference model.
module tb_ram_sdp_clr;

    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;
    localparam int NDUT  = 2;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear_i = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [1:0]    wr_be = '0;

    logic          ready0, ready1;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;

    int            lat  [NDUT] = '{1, 2};
    int            mode [NDUT] = '{0, 1};
    logic [15:0]   cval [NDUT] = '{16'h0000, 16'hA5A5};
    logic [15:0]   mem_m [NDUT][DEPTH];
    logic [15:0]   last_m [NDUT];
    exp_t          q0[$];
    exp_t          q1[$];
    int            clear_left;
    int            edge_n;
    int            checks;
    int            errors;

    always #5 clk = ~clk;

    ram_sdp_clr #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .READ_LATENCY (1),
        .RDW_MODE     (0),
        .CLEAR_VALUE  (16'h0000)
    ) dut0 (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (clear_i),
        .ready_o  (ready0),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rdata0),
        .rd_valid (rvalid0)
    );

    ram_sdp_clr #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .READ_LATENCY (2),
        .RDW_MODE     (1),
        .CLEAR_VALUE  (16'hA5A5)
    ) dut1 (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (clear_i),
        .ready_o  (ready1),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rdata1),
        .rd_valid (rvalid1)
    );

    function automatic logic [15:0] merge16(input logic [15:0] o,
                                            input logic [15:0] n,
                                            input logic [1:0]  be);
        return {be[1] ? n[15:8] : o[15:8], be[0] ? n[7:0] : o[7:0]};
    endfunction

    task automatic check_dut(input int k, input logic rdy,
                             input logic vld, input logic [15:0] dat,
                             input string tag);
        logic ev;
        logic er;
        ev = 1'b0;
        er = (clear_left == 0);
        if (k == 0) begin
            if (q0.size() > 0 && q0[0].due == edge_n) begin
                ev = 1'b1;
                last_m[0] = q0[0].data;
                void'(q0.pop_front());
            end
        end else begin
            if (q1.size() > 0 && q1[0].due == edge_n) begin
                ev = 1'b1;
                last_m[1] = q1[0].data;
                void'(q1.pop_front());
            end
        end
        checks++;
        assert (rdy === er) else begin
            errors++;
            $error("FAIL %s dut%0d ready_o edge %0d: got %b expected %b",
                   tag, k, edge_n, rdy, er);
        end
        checks++;
        assert (vld === ev) else begin
            errors++;
            $error("FAIL %s dut%0d rd_valid edge %0d: got %b expected %b",
                   tag, k, edge_n, vld, ev);
        end
        checks++;
        assert (dat === last_m[k]) else begin
            errors++;
            $error("FAIL %s dut%0d rd_data edge %0d: got %h expected %h",
                   tag, k, edge_n, dat, last_m[k]);
        end
    endtask

    task automatic check_all(input string tag);
        check_dut(0, ready0, rvalid0, rdata0, tag);
        check_dut(1, ready1, rvalid1, rdata1, tag);
    endtask

    // One clock cycle: drive inputs, predict, clock, then compare.
    task automatic step(input logic rst, input logic clr,
                        input logic we, input logic [AW-1:0] wa,
                        input logic [15:0] wd, input logic [1:0] be,
                        input logic re, input logic [AW-1:0] ra,
                        input string tag);
        logic rdy;
        exp_t e;
        rdy = 1'b0;
        reset = rst;
        clear_i = clr;
        wr_en = we;
        wr_addr = wa;
        wr_data = wd;
        wr_be = be;
        rd_en = re;
        rd_addr = ra;
        if (rst) begin
            q0.delete();
            q1.delete();
            last_m[0] = '0;
            last_m[1] = '0;
            clear_left = DEPTH;
            #1;
            check_all({tag, "_async"});
        end else begin
            rdy = (clear_left == 0);
            if (rdy && re) begin
                for (int k = 0; k < NDUT; k++) begin
                    e.data = mem_m[k][ra];
                    if (mode[k] == 1 && we && wa == ra) begin
                        e.data = merge16(e.data, wd, be);
                    end
                    e.due = edge_n + lat[k];
                    if (k == 0) q0.push_back(e);
                    else q1.push_back(e);
                end
            end
        end
        @(posedge clk);
        edge_n++;
        if (!rst) begin
            if (rdy && we) begin
                for (int k = 0; k < NDUT; k++) begin
                    mem_m[k][wa] = merge16(mem_m[k][wa], wd, be);
                end
            end
            if (rdy && clr) begin
                clear_left = DEPTH;
            end else if (clear_left > 0) begin
                if (clear_left == DEPTH) begin
                    for (int a = 0; a < DEPTH; a++) begin
                        mem_m[0][a] = cval[0];
                        mem_m[1][a] = cval[1];
                    end
                end
                clear_left--;
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0, '0, '0, '0, 0, '0, "idle");
        end
    endtask

    task automatic rd(input logic [AW-1:0] a, input string tag);
        step(0, 0, 0, '0, '0, '0, 1, a, tag);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [15:0] d,
                      input logic [1:0] be, input string tag);
        step(0, 0, 1, a, d, be, 0, '0, tag);
    endtask

    // Random traffic; clear_i is only toggled while a sweep is running.
    task automatic rand_steps(input int n, input logic [AW-1:0] amask,
                              input string tag);
        logic clr;
        for (int i = 0; i < n; i++) begin
            clr = (clear_left != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            step(0, clr, 1'($urandom), AW'($urandom) & amask,
                 16'($urandom), 2'($urandom), 1'($urandom),
                 AW'($urandom) & amask, tag);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        edge_n = 0;
        clear_left = DEPTH;
        last_m[0] = '0;
        last_m[1] = '0;

        step(1, 0, 0, '0, '0, '0, 0, '0, "reset");
        step(1, 1, 1, 12'd3, 16'hFFFF, 2'b11, 1, 12'd3, "reset");
        rand_steps(DEPTH, '1, "boot_sweep");

        rd(12'd0, "rd_a0");
        rd(12'd2048, "rd_a2048");
        rd(12'd4095, "rd_a4095");
        idle(3);

        wr(12'd5, 16'h1234, 2'b11, "wr5_full");
        wr(12'd5, 16'hABCD, 2'b01, "wr5_lo");
        rd(12'd5, "rd5_merge");
        wr(12'd5, 16'hFFFF, 2'b00, "wr5_be0");
        rd(12'd5, "rd5_be0");
        idle(3);

        wr(12'd7, 16'h0001, 2'b11, "wr7");
        step(0, 0, 1, 12'd7, 16'hFFFF, 2'b11, 1, 12'd7, "rdw7");
        rd(12'd7, "rd7_after");
        idle(3);

        rd(12'd5, "burst0");
        rd(12'd7, "burst1");
        rd(12'd0, "burst2");
        rd(12'd5, "burst3");
        idle(4);

        rand_steps(1500, 12'h00F, "rand_lo");
        rand_steps(500, '1, "rand_all");

        wr(12'd100, 16'h5555, 2'b11, "wr100");
        step(0, 1, 1, 12'd101, 16'h1111, 2'b11, 1, 12'd100, "clear_req");
        rand_steps(DEPTH, '1, "clear_sweep");
        rd(12'd100, "rd100_clr");
        rd(12'd101, "rd101_clr");
        idle(3);

        wr(12'd100, 16'h5555, 2'b11, "wr100b");
        step(0, 1, 0, '0, '0, '0, 0, '0, "clear_req2");
        rand_steps(1000, '1, "sweep_part");
        step(1, 0, 0, '0, '0, '0, 0, '0, "reset_mid");
        rand_steps(DEPTH, '1, "sweep_restart");
        rd(12'd100, "rd100_rst");
        idle(2);

        rand_steps(40, 12'h007, "rand_pre_rst");
        step(1, 0, 0, '0, '0, '0, 0, '0, "reset_rd");
        rand_steps(DEPTH, '1, "sweep_rd_rst");
        rand_steps(300, 12'h00F, "rand_final");
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_sdp_clr.md
# ram_sdp_clr

Parametrised simple-dual-port synchronous RAM with byte-enable writes, selectable read latency, defined read-during-write behaviour and a hardware clear sequencer. It is the general-purpose on-chip memory for the datapath: one write port, one read port, both on `clk`. After reset, or on request, it holds a `ready_o`-gated sweep that initialises every word to a known value.

## Interface
Parameters:
- `ADDR_W`, 12, address width; depth = 2^ADDR_W words.
- `DATA_W`, 16, word width; must be a multiple of 8.
- `READ_LATENCY`, 1, cycles from read request to data; legal values are 1 and 2.
- `RDW_MODE`, 0, read-during-write to the same address: 0 = old data, 1 = new (merged) data.
- `CLEAR_VALUE`, 0, `DATA_W`-bit value written by the clear sweep.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high.
- `clear_i`  in  1  pulse requesting a full-array clear sweep.
- `ready_o`  out  1  high when user reads and writes are accepted.
- `wr_en`  in  1  write request.
- `wr_addr`  in  `ADDR_W`  write address.
- `wr_data`  in  `DATA_W`  write data.
- `wr_be`  in  `DATA_W/8`  byte enables; bit i covers `wr_data[8i+7:8i]`.
- `rd_en`  in  1  read request.
- `rd_addr`  in  `ADDR_W`  read address.
- `rd_data`  out  `DATA_W`  read data; holds its value between reads.
- `rd_valid`  out  1  one-cycle pulse marking valid `rd_data`.

## Operation
- Reset values: `ready_o`=0, `rd_valid`=0, `rd_data`=0, all pipeline valids=0, sequencer in CLEAR with counter=0. The array itself is not reset.
- The sequencer has two states:
  - CLEAR: writes `CLEAR_VALUE` to address `cnt` on each edge, then increments `cnt`. When `cnt` = 2^ADDR_W−1 is written, the next state is IDLE. `ready_o`=0.
  - IDLE: `ready_o`=1. `clear_i`=1 moves to CLEAR with `cnt`=0 on the next edge.
- `clear_i` asserted during CLEAR is ignored; the sweep is not restarted.
- Reset asserted mid-sweep or mid-read flushes everything. The sweep restarts from address 0 after reset deasserts.
- While `ready_o`=0, `wr_en` and `rd_en` are ignored. No write occurs and no `rd_valid` is produced. Reads already in the pipeline when a clear starts still complete.
- A write updates only the bytes whose `wr_be` bit is 1. `wr_be`=0 with `wr_en`=1 is a no-op.
- A read is accepted when `rd_en`=1 and `ready_o`=1.
- `rd_data` changes only on a cycle where `rd_valid` is 1; otherwise it holds.
- Simultaneous read and write to the same address in one cycle:
  - `RDW_MODE`=0: returns the pre-write word.
  - `RDW_MODE`=1: returns the pre-write word with the enabled bytes replaced by `wr_data`.
- Simultaneous accesses to different addresses are independent.
- Back-to-back reads give full throughput: one result per cycle.

## Timing
- Read latency: a read accepted at edge N presents data and `rd_valid`=1 after edge N+`READ_LATENCY`. Latency 2 adds one output register stage.
- A write at edge N is visible to a read issued at edge N+1 in either mode.
- Sweep duration: the first edge after reset deassertion writes address 0. `ready_o` rises after edge 2^ADDR_W, i.e. 4096 edges for the defaults.
- `ready_o` falls one edge after `clear_i` is sampled in IDLE. A user write accepted in that same cycle still completes.

## Structure
- Shared package `ram_pkg` holds:
  - the `RDW_OLD`/`RDW_NEW` constants;
  - a byte-merge function taking old word, new word and byte enables;
  - elaboration-time checks: `DATA_W`%8==0 and `READ_LATENCY`∈{1,2}.
- Sub-module `ram_clear_seq` contains the CLEAR/IDLE FSM and the address counter. It outputs `ready_o`, the clear write enable and the clear address.
- The top level contains:
  - the array;
  - the write mux between the sequencer and the user port;
  - the RDW forwarding compare;
  - the optional output stage.

## Test plan
- Reset, then release with defaults -> `ready_o` stays 0 for 4096 edges, then goes 1. Reading addresses 0, 2048 and 4095 returns 0x0000 with `rd_valid` one cycle after each request.
- Write 0xABCD with `wr_be`=2'b01 to address 5, which holds 0x1234 -> reading address 5 returns 0x12CD. A write with `wr_be`=0 leaves it at 0x12CD.
- Same-cycle read and write to address 7 (old value 0x0001, new value 0xFFFF, `wr_be`=2'b11) -> `RDW_MODE`=0 returns 0x0001, `RDW_MODE`=1 returns 0xFFFF. The next read returns 0xFFFF in both modes.
- `READ_LATENCY`=2 with reads on 4 consecutive cycles -> 4 consecutive `rd_valid` pulses starting 2 edges after the first request, data in request order, and `rd_data` held afterwards.
- Pulse `clear_i` in IDLE after writing 0x5555 to address 100 -> `ready_o` drops next edge and user requests are ignored during the sweep. After 4096 edges, address 100 reads `CLEAR_VALUE`.
- Assert `reset` at sweep address 1000 -> outputs return to reset values immediately, and the sweep restarts from 0 lasting a full 4096 edges.
